// File: rtl/servo_pulse_decoder.sv
// Servo PWM receiver: conditions the raw pin, measures each frame's high time
// and rise-to-rise period, and reports width/position, frame errors, lock and
// loss of signal.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SYNC      | discard a pulse in progress; wait for a settled low level
// WAIT_RISE | level low, no frame open; next rise opens the first frame
// HIGH      | frame open, level high, high-time counter running
// LOW       | frame open, level low; next rise closes and judges the frame
module servo_pulse_decoder #(
    parameter int FILTER_CYCLES = 4,
    parameter int MIN_HIGH      = 20000,
    parameter int MAX_HIGH      = 130000,
    parameter int MIN_PERIOD    = 500000,
    parameter int MAX_PERIOD    = 1100000,
    parameter int TIMEOUT       = 1500000,
    parameter int LOCK_FRAMES   = 3
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        servo_in,
    output logic [20:0] width,
    output logic [16:0] position,
    output logic        valid,
    output logic        locked,
    output logic        err_width,
    output logic        err_period,
    output logic        signal_lost
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [20:0] CNT_MAX  = '1;
    localparam logic [GW-1:0] GOOD_MAX = '1;

    typedef enum logic [1:0] {S_SYNC, S_WAIT_RISE, S_HIGH, S_LOW} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_sync1, r_sync2;
    logic           r_filt, r_filt_q;
    logic           r_primed;
    logic [FW-1:0]  r_fcnt;
    logic [20:0]    r_hi, r_per, r_to;
    logic [GW-1:0]  r_good;

    logic           w_rise, w_fall, w_quiet_low, w_timeout;
    logic           w_start, w_eval, w_count_hi, w_count_per;
    logic           w_width_ok, w_period_ok;
    logic [16:0]    w_pos;
    logic [GW-1:0]  w_good_inc;

    // Two-flop synchronizer and glitch filter; both edges see the same delay.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_filt   <= 1'b0;
            r_filt_q <= 1'b0;
            r_primed <= 1'b0;
            r_fcnt   <= '0;
        end else begin
            r_sync1  <= servo_in;
            r_sync2  <= r_sync1;
            r_filt_q <= r_filt;
            r_primed <= 1'b1;
            if (r_sync2 != r_filt) begin
                if (r_fcnt == FW'(FILTER_CYCLES - 1)) begin
                    r_filt <= r_sync2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_rise = r_filt & ~r_filt_q;
    assign w_fall = ~r_filt & r_filt_q;
    // The synchronizer flops read as low straight out of reset, so a settled
    // low is only trusted once they have sampled the pin at least once.
    assign w_quiet_low = r_primed & ~r_filt & ~r_sync1 & ~r_sync2 & (r_fcnt == '0);

    // Loss-of-signal timer: reloads on every filtered rise, expires on the 1->0 step.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_to <= '0;
        end else if (w_rise) begin
            r_to <= 21'(TIMEOUT - 1);
        end else if (r_to != '0) begin
            r_to <= r_to - 21'd1;
        end
    end

    assign w_timeout = ~w_rise & (r_to == 21'd1);

    // FSM state register.
    always_ff @(posedge mclk) begin
        if (rst) r_state <= S_SYNC;
        else     r_state <= w_next;
    end

    // FSM next-state; a timeout overrides whatever the frame logic wanted.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SYNC:      if (w_quiet_low) w_next = S_WAIT_RISE;
            S_WAIT_RISE: if (w_rise)      w_next = S_HIGH;
            S_HIGH:      if (w_fall)      w_next = S_LOW;
            S_LOW:       if (w_rise)      w_next = S_HIGH;
            default:                      w_next = S_SYNC;
        endcase
        if (w_timeout) w_next = r_filt ? S_SYNC : S_WAIT_RISE;
    end

    // FSM outputs: frame start/close and which counters run.
    always_comb begin
        w_start     = 1'b0;
        w_eval      = 1'b0;
        w_count_hi  = 1'b0;
        w_count_per = 1'b0;
        case (r_state)
            S_WAIT_RISE: w_start = w_rise;
            S_HIGH: begin
                w_count_hi  = r_filt;
                w_count_per = 1'b1;
            end
            S_LOW: begin
                w_start     = w_rise;
                w_eval      = w_rise;
                w_count_per = 1'b1;
            end
            default: ;
        endcase
    end

    // High-time and period counters; the rise clock itself counts as the first.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_hi  <= '0;
            r_per <= '0;
        end else if (w_start) begin
            r_hi  <= 21'd1;
            r_per <= 21'd1;
        end else begin
            if (w_count_hi && r_hi != CNT_MAX)   r_hi  <= r_hi + 21'd1;
            if (w_count_per && r_per != CNT_MAX) r_per <= r_per + 21'd1;
        end
    end

    assign w_width_ok  = (r_hi >= 21'(MIN_HIGH)) && (r_hi <= 21'(MAX_HIGH));
    assign w_period_ok = (r_per >= 21'(MIN_PERIOD)) && (r_per <= 21'(MAX_PERIOD));
    assign w_pos       = 17'(r_hi - 21'(MIN_HIGH));
    assign w_good_inc  = (r_good == GOOD_MAX) ? r_good : r_good + GW'(1);

    // Frame verdict, lock tracking and loss-of-signal flag.
    always_ff @(posedge mclk) begin
        if (rst) begin
            width       <= '0;
            position    <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            err_width   <= 1'b0;
            err_period  <= 1'b0;
            signal_lost <= 1'b1;
            r_good      <= '0;
        end else begin
            valid      <= 1'b0;
            err_width  <= 1'b0;
            err_period <= 1'b0;
            if (w_eval) begin
                if (w_width_ok && w_period_ok) begin
                    width       <= r_hi;
                    position    <= w_pos;
                    valid       <= 1'b1;
                    r_good      <= w_good_inc;
                    locked      <= (w_good_inc >= GW'(LOCK_FRAMES));
                    signal_lost <= 1'b0;
                end else begin
                    err_width  <= ~w_width_ok;
                    err_period <= ~w_period_ok;
                    r_good     <= '0;
                    locked     <= 1'b0;
                end
            end else if (w_timeout) begin
                signal_lost <= 1'b1;
                locked      <= 1'b0;
                r_good      <= '0;
            end
        end
    end

endmodule
